// File: rtl/rs_cd_pkg.sv
// GF(2^8) helpers and shared types for the CD CIRC Reed-Solomon syndrome engine.
package rs_cd_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;

    typedef enum logic [1:0] {
        CELL_HOLD,
        CELL_CLEAR,
        CELL_LOAD,
        CELL_ACC
    } cell_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } out_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a, input logic [8:0] poly);
        return a[7] ? ({a[6:0], 1'b0} ^ poly[7:0]) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e, input logic [8:0] poly = GF_POLY);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < (e % 255); i++) begin
            r = gf_xtime(r, poly);
        end
        return r;
    endfunction

    // Shift-and-add product; with c constant this folds into an XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c,
                                                input logic [8:0] poly = GF_POLY);
        logic [7:0] acc;
        logic [7:0] b;
        acc = 8'h00;
        b   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ b;
            b = gf_xtime(b, poly);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_syndrome_engine_if.sv
// Byte-serial syndrome stream with valid/ready handshake, status flags travel alongside.
interface rs_syndrome_engine_if;
    logic [7:0] o_syn_data;
    logic       o_syn_valid;
    logic       i_syn_ready;
    logic       o_syn_last;
    logic       o_zero;

    modport master (output o_syn_data, o_syn_valid, o_syn_last, o_zero, input i_syn_ready);
    modport slave  (input o_syn_data, o_syn_valid, o_syn_last, o_zero, output i_syn_ready);
endinterface

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: Horner step S <= S*alpha^ROOT_EXP ^ data over GF(2^8).
module rs_syn_cell
    import rs_cd_pkg::*;
#(
    parameter int         ROOT_EXP = 0,
    parameter logic [8:0] POLY     = GF_POLY
) (
    input  logic       i_clk,
    input  logic       i_resb,
    input  cell_op_e   i_op,
    input  logic [7:0] i_data,
    output logic [7:0] o_syn
);
    localparam logic [7:0] ROOT = gf_alpha_pow(ROOT_EXP, POLY);

    logic [7:0] syn_q;
    logic [7:0] syn_d;

    // NOTE: next-state defaults to the held value first, so no path can infer a latch.
    always_comb begin
        syn_d = syn_q;
        unique case (i_op)
            CELL_CLEAR: syn_d = 8'h00;
            CELL_LOAD:  syn_d = i_data;
            CELL_ACC:   syn_d = gf_mul_const(syn_q, ROOT, POLY) ^ i_data;
            default:    syn_d = syn_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_resb) syn_q <= 8'h00;
        else         syn_q <= syn_d;
    end

    assign o_syn = syn_q;

endmodule

// File: rtl/rs_syndrome_engine.sv
// Syndrome engine top: byte counter and frame handling, NSYN Horner cells, and a
// single-entry output buffer streamed byte-serially by a two-state FSM.
module rs_syndrome_engine
    import rs_cd_pkg::*;
#(
    parameter int         NSYN    = 4,
    parameter int         N_BYTES = 32,
    parameter int         FCR     = 0,
    parameter logic [8:0] POLY    = GF_POLY
) (
    input  logic                        i_clk,
    input  logic                        i_resb,
    input  logic                        i_frame_sync,
    input  logic [7:0]                  i_data,
    input  logic                        i_data_sync,
    rs_syndrome_engine_if.master        syn_if,
    output logic                        o_overrun,
    output logic                        o_short
);
    localparam int              CW       = $clog2(N_BYTES + 1);
    localparam int              IW       = $clog2(NSYN);
    localparam logic [CW-1:0]   CNT_FULL = CW'(N_BYTES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N_BYTES - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NSYN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          short_q, short_d;
    cell_op_e      cell_op;
    logic [7:0]    syn [NSYN];

    for (genvar j = 0; j < NSYN; j++) begin : g_cell
        rs_syn_cell #(.ROOT_EXP(FCR + j), .POLY(POLY)) u_cell (
            .i_clk  (i_clk),
            .i_resb (i_resb),
            .i_op   (cell_op),
            .i_data (i_data),
            .o_syn  (syn[j])
        );
    end

    // A frame sync outranks the post-completion clear so byte 0 of the next word is never lost.
    always_comb begin
        cell_op = CELL_HOLD;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        short_d = 1'b0;
        if (done_q) cell_op = CELL_CLEAR;
        if (i_frame_sync) begin
            short_d = (cnt_q != '0) && (cnt_q < CNT_FULL);
            cell_op = i_data_sync ? CELL_LOAD : CELL_CLEAR;
            cnt_d   = i_data_sync ? CW'(1) : '0;
        end else if (i_data_sync && (cnt_q < CNT_FULL)) begin
            cell_op = CELL_ACC;
            cnt_d   = cnt_q + CW'(1);
            done_d  = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resb) begin
            cnt_q   <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end

    out_state_e    state_q;
    logic [7:0]    buf_q [NSYN];
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt;
    logic [7:0]    data_q;
    logic          last_q, zero_q, overrun_q;
    logic          hs, buf_free, set_zero;

    assign hs       = (state_q == ST_SEND) && syn_if.i_syn_ready;
    assign buf_free = (state_q == ST_IDLE) || (hs && last_q);
    assign idx_nxt  = idx_q + IW'(1);

    always_comb begin
        set_zero = 1'b1;
        for (int j = 0; j < NSYN; j++) begin
            if (syn[j] != 8'h00) set_zero = 1'b0;
        end
    end

    // NOTE: the buffer array is reset explicitly because the stream must read back zero after reset.
    always_ff @(posedge i_clk) begin
        if (!i_resb) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            zero_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int j = 0; j < NSYN; j++) buf_q[j] <= 8'h00;
        end else begin
            overrun_q <= 1'b0;
            if (hs) begin
                if (last_q) begin
                    state_q <= ST_IDLE;
                    last_q  <= 1'b0;
                    zero_q  <= 1'b0;
                end else begin
                    idx_q  <= idx_nxt;
                    data_q <= buf_q[idx_nxt];
                    last_q <= (idx_nxt == IDX_LAST);
                end
            end
            if (done_q) begin
                if (buf_free) begin
                    for (int j = 0; j < NSYN; j++) buf_q[j] <= syn[j];
                    state_q <= ST_SEND;
                    idx_q   <= '0;
                    data_q  <= syn[0];
                    last_q  <= 1'b0;
                    zero_q  <= set_zero;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign syn_if.o_syn_valid = (state_q == ST_SEND);
    assign syn_if.o_syn_data  = data_q;
    assign syn_if.o_syn_last  = last_q;
    assign syn_if.o_zero      = zero_q;
    assign o_overrun          = overrun_q;
    assign o_short            = short_q;

endmodule
